// File: rtl/ifetch.sv
// Instruction fetch stage: credit-throttled memory requests, 2-entry in-order
// instruction buffer, and discard of in-flight responses after a redirect.
module ifetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic        pc_adv,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [1:0]  disc_q, disc_d;

    logic [31:0] buf_pc_q  [2];
    logic [31:0] buf_ins_q [2];
    logic [1:0]  buf_flt_q;
    logic        buf_rd_q, buf_wr_q;
    logic [1:0]  buf_cnt_q, buf_cnt_d;

    logic [31:0] oq_pc_q [2];
    logic        oq_rd_q, oq_wr_q;
    logic [1:0]  out_cnt_q, out_cnt_d;

    logic [2:0]  occ_s;
    logic        credit_s, aligned_s, rsp_s, accept_s, fault_push_s;
    logic        rsp_push_s, push_s, pop_s;
    logic [31:0] push_pc_s, push_ins_s;

    assign occ_s      = {1'b0, buf_cnt_q} + {1'b0, out_cnt_q};
    assign credit_s   = (occ_s < 3'd2);
    assign aligned_s  = (pc_in[1:0] == 2'b00);
    // A beat arriving with nothing outstanding has no owner and is ignored.
    assign rsp_s      = imem_rvalid & (out_cnt_q != 2'd0);
    assign imem_addr  = pc_in;
    assign rsp_push_s = (state_q == RUN) & ~redirect & rsp_s;
    assign push_s     = rsp_push_s | fault_push_s;
    assign pop_s      = inst_valid & inst_ready;
    assign push_pc_s  = fault_push_s ? pc_in : oq_pc_q[oq_rd_q];
    assign push_ins_s = fault_push_s ? NOP_INSN : imem_rdata;
    assign buf_cnt_d  = redirect ? 2'd0 : (buf_cnt_q + {1'b0, push_s} - {1'b0, pop_s});
    assign out_cnt_d  = out_cnt_q + {1'b0, accept_s} - {1'b0, rsp_s};

    // FSM state and discard counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            disc_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            disc_q  <= disc_d;
        end
    end

    // Next state: a redirect discards whatever is still in flight
    always_comb begin
        state_d = state_q;
        disc_d  = disc_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    disc_d  = out_cnt_q - {1'b0, rsp_s};
                    state_d = (disc_d != 2'd0) ? FLUSH : RUN;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (rsp_s && (disc_q != 2'd0)) begin
                    disc_d  = disc_q - 2'd1;
                    state_d = (disc_d == 2'd0) ? RUN : FLUSH;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = RUN;
                disc_d  = 2'd0;
            end
        endcase
    end

    // Outputs: request/fault issue and buffer head presentation
    always_comb begin
        imem_req     = 1'b0;
        fault_push_s = 1'b0;
        if (reset && (state_q == RUN) && !redirect && credit_s) begin
            if (aligned_s) begin
                imem_req = 1'b1;
            end else if (out_cnt_q == 2'd0) begin
                fault_push_s = 1'b1;
            end else begin
                fault_push_s = 1'b0;
            end
        end else begin
            imem_req = 1'b0;
        end
        accept_s    = imem_req & imem_gnt;
        pc_adv      = accept_s | fault_push_s;
        inst_valid  = reset & (buf_cnt_q != 2'd0) & ~redirect;
        inst_out    = buf_ins_q[buf_rd_q];
        inst_pc     = buf_pc_q[buf_rd_q];
        fetch_fault = buf_flt_q[buf_rd_q];
    end

    // Instruction buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_pc_q[0]  <= 32'd0;
            buf_pc_q[1]  <= 32'd0;
            buf_ins_q[0] <= 32'd0;
            buf_ins_q[1] <= 32'd0;
            buf_flt_q    <= 2'b00;
            buf_rd_q     <= 1'b0;
            buf_wr_q     <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            buf_cnt_q <= buf_cnt_d;
            if (redirect) begin
                buf_rd_q <= 1'b0;
                buf_wr_q <= 1'b0;
            end else begin
                if (push_s) begin
                    buf_pc_q[buf_wr_q]  <= push_pc_s;
                    buf_ins_q[buf_wr_q] <= push_ins_s;
                    buf_flt_q[buf_wr_q] <= fault_push_s;
                    buf_wr_q            <= ~buf_wr_q;
                end
                if (pop_s) begin
                    buf_rd_q <= ~buf_rd_q;
                end
            end
        end
    end

    // Outstanding-address queue; survives redirect so late beats stay matched
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oq_pc_q[0] <= 32'd0;
            oq_pc_q[1] <= 32'd0;
            oq_rd_q    <= 1'b0;
            oq_wr_q    <= 1'b0;
            out_cnt_q  <= 2'd0;
        end else begin
            out_cnt_q <= out_cnt_d;
            if (accept_s) begin
                oq_pc_q[oq_wr_q] <= pc_in;
                oq_wr_q          <= ~oq_wr_q;
            end
            if (rsp_s) begin
                oq_rd_q <= ~oq_rd_q;
            end
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a PC register model and an in-order memory
// model drive the DUT; expected instructions are queued when pc_adv fires.
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = 32'd0;
    logic        pc_adv;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    ifetch dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_adv(pc_adv),
        .redirect(redirect), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    logic [31:0] target = 32'd0;
    bit          mem_hold = 1'b0;
    int          stall_pct = 0;
    int          grants = 0;
    int          advs = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memdata(input logic [31:0] a);
        return {a[23:0], 8'h00} + 32'h0050_0093;
    endfunction

    // One clock: observe at negedge, apply PC/memory updates just after posedge.
    task automatic tick();
        logic [31:0] npc;
        bit          rsp;
        exp_t        e;
        @(negedge clk);
        npc = pc_in;
        rsp = 1'b0;
        if (reset) begin
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", {31'd0, inst_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("inst_pc", inst_pc, e.pc);
                    chk("inst_out", inst_out, e.ins);
                    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, e.flt});
                end
            end
            if (imem_req && imem_gnt) begin
                mem_q.push_back(pc_in);
                grants++;
            end
            if (pc_adv) begin
                advs++;
                e.pc  = pc_in;
                e.flt = (pc_in[1:0] != 2'b00);
                e.ins = e.flt ? 32'h0000_0013 : memdata(pc_in);
                exp_q.push_back(e);
            end
            if (redirect) begin
                exp_q.delete();
                npc = target;
            end else if (pc_adv) begin
                npc = pc_in + 32'd4;
            end
            rsp = (mem_q.size() > 0) && !mem_hold && (int'($urandom_range(99)) >= stall_pct);
        end else begin
            exp_q.delete();
            mem_q.delete();
        end
        @(posedge clk);
        #1;
        pc_in = npc;
        if (reset) begin
            imem_rvalid = rsp;
            imem_rdata  = rsp ? memdata(mem_q.pop_front()) : 32'hDEAD_BEEF;
        end
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_adv", {31'd0, pc_adv}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_out", inst_out, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);

        // Single fetch from PC 0
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("f0_req", {31'd0, imem_req}, 32'd1);
        chk("f0_addr", imem_addr, 32'd0);
        chk("f0_adv", {31'd0, pc_adv}, 32'd1);
        tick();
        imem_gnt = 1'b0;
        #1;
        chk("f0_not_yet", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("f0_valid", {31'd0, inst_valid}, 32'd1);
        chk("f0_out", inst_out, 32'h0050_0093);
        chk("f0_pc", inst_pc, 32'd0);
        chk("f0_adv_once", advs, 32'd1);
        repeat (3) tick();

        // Credit limit: decode stalled, continuous grant
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        grants     = 0;
        pc_in      = 32'h4;
        #1;
        tick();
        tick();
        chk("cr_third_req", {31'd0, imem_req}, 32'd0);
        chk("cr_third_adv", {31'd0, pc_adv}, 32'd0);
        repeat (3) tick();
        chk("cr_grants", grants, 32'd2);
        chk("cr_valid", {31'd0, inst_valid}, 32'd1);
        chk("cr_pc0", inst_pc, 32'h4);
        inst_ready = 1'b1;
        #1;
        tick();
        chk("cr_pc1", inst_pc, 32'h8);
        imem_gnt = 1'b0;
        repeat (3) tick();
        chk("cr_drained", exp_q.size(), 32'd0);

        // Redirect with two outstanding requests
        inst_ready = 1'b0;
        mem_hold   = 1'b1;
        imem_gnt   = 1'b1;
        pc_in      = 32'h10;
        #1;
        tick();
        tick();
        redirect = 1'b1;
        target   = 32'h40;
        #1;
        chk("rd_req_sup", {31'd0, imem_req}, 32'd0);
        chk("rd_adv_sup", {31'd0, pc_adv}, 32'd0);
        tick();
        redirect = 1'b0;
        #1;
        chk("fl_req0", {31'd0, imem_req}, 32'd0);
        mem_hold = 1'b0;
        tick();
        chk("fl_req1", {31'd0, imem_req}, 32'd0);
        tick();
        chk("fl_req2", {31'd0, imem_req}, 32'd0);
        chk("fl_novalid", {31'd0, inst_valid}, 32'd0);
        tick();
        chk("fl_resume_req", {31'd0, imem_req}, 32'd1);
        chk("fl_resume_addr", imem_addr, 32'h40);
        tick();
        imem_gnt = 1'b0;
        tick();
        chk("fl_valid", {31'd0, inst_valid}, 32'd1);
        chk("fl_pc", inst_pc, 32'h40);
        inst_ready = 1'b1;
        repeat (2) tick();
        chk("fl_drained", exp_q.size(), 32'd0);

        // Misaligned PC produces a fault entry without a memory request
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        pc_in      = 32'h22;
        #1;
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_adv", {31'd0, pc_adv}, 32'd1);
        tick();
        chk("mis_valid", {31'd0, inst_valid}, 32'd1);
        chk("mis_out", inst_out, 32'h0000_0013);
        chk("mis_pc", inst_pc, 32'h22);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        inst_ready = 1'b1;
        tick();
        redirect = 1'b1;
        target   = 32'h100;
        tick();
        redirect = 1'b0;

        // Reset asserted mid-transaction
        inst_ready = 1'b0;
        imem_gnt   = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("mr_req", {31'd0, imem_req}, 32'd0);
        chk("mr_adv", {31'd0, pc_adv}, 32'd0);
        chk("mr_valid", {31'd0, inst_valid}, 32'd0);
        chk("mr_out", inst_out, 32'd0);
        chk("mr_pc", inst_pc, 32'd0);
        chk("mr_fault", {31'd0, fetch_fault}, 32'd0);
        imem_rvalid = 1'b1;
        repeat (2) tick();
        chk("mr_hold_valid", {31'd0, inst_valid}, 32'd0);
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        reset      = 1'b1;
        #1;
        chk("mr_rel_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        tick();
        chk("mr_stale_valid", {31'd0, inst_valid}, 32'd0);

        // Randomised traffic checked by the scoreboard
        stall_pct = 30;
        pc_in     = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            imem_gnt   = ($urandom_range(3) != 0);
            inst_ready = ($urandom_range(2) != 0);
            if ($urandom_range(31) == 0) begin
                redirect = 1'b1;
                target   = ($urandom & 32'h0000_FFFC) | (($urandom_range(7) == 0) ? 32'h2 : 32'h0);
            end
            #1;
            tick();
            redirect = 1'b0;
        end

        // Drain: everything issued must come out
        stall_pct  = 0;
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        redirect   = 1'b1;
        target     = 32'h3000;
        tick();
        redirect = 1'b0;
        repeat (6) tick();
        imem_gnt = 1'b1;
        repeat (5) tick();
        imem_gnt = 1'b0;
        repeat (8) tick();
        chk("end_exp_empty", exp_q.size(), 32'd0);
        chk("end_mem_empty", mem_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
